// File: rtl/i2c_addr_tx_if.sv
// Bus between the master FSM / SCL generator and the I2C address-phase transmitter.
// The master modport is the driving side; the slave modport is the transmitter.
interface i2c_addr_tx_if #(parameter int ADDR_W = 7);
  logic              go;
  logic              abort;
  logic [ADDR_W-1:0] addr;
  logic              rw;
  logic              mode10;
  logic              scl_fall;
  logic              scl_rise;
  logic              sda_in;
  logic              rs_done;
  logic              sda_low;
  logic              busy;
  logic              rs_req;
  logic              done;
  logic              nack;

  modport master (
    output go, abort, addr, rw, mode10, scl_fall, scl_rise, sda_in, rs_done,
    input  sda_low, busy, rs_req, done, nack
  );

  modport slave (
    input  go, abort, addr, rw, mode10, scl_fall, scl_rise, sda_in, rs_done,
    output sda_low, busy, rs_req, done, nack
  );
endinterface

// File: rtl/i2c_addr_tx.sv
// I2C address-phase transmitter: shifts 7-bit or 10-bit address bytes onto SDA, samples
// each ACK, and for 10-bit reads requests a repeated START before the R/W=1 header.
module i2c_addr_tx #(
  parameter int ADDR_W = 7
) (
  input logic         clk,
  input logic         reset_n,
  i2c_addr_tx_if.slave bus
);
  // state   | meaning
  // IDLE    | waiting for go
  // SHIFT   | driving bit_idx of cur byte, advancing on scl_fall
  // ACK     | SDA released, ack sampled on scl_rise, decided on scl_fall
  // RS_WAIT | repeated START requested, waiting for rs_done
  // FIN     | one-cycle done pulse
  typedef enum logic [2:0] {IDLE, SHIFT, ACK, RS_WAIT, FIN} state_t;

  state_t     state;
  logic [7:0] b1, b2, cur;
  logic [2:0] bit_idx;
  logic [1:0] byte_sel, last_sel;
  logic       ack_bit;
  logic       sda_low_q, busy_q, rs_req_q, done_q, nack_q;

  logic [9:0] addr_ext;
  logic       mode10_eff;
  logic [7:0] go_b0, go_b1, go_b2;

  assign addr_ext   = 10'(bus.addr);
  assign mode10_eff = (ADDR_W >= 10) ? bus.mode10 : 1'b0;
  assign go_b0      = mode10_eff ? {5'b11110, addr_ext[9:8], 1'b0} : {addr_ext[6:0], bus.rw};
  assign go_b1      = addr_ext[7:0];
  assign go_b2      = {5'b11110, addr_ext[9:8], 1'b1};

  assign bus.sda_low = sda_low_q;
  assign bus.busy    = busy_q;
  assign bus.rs_req  = rs_req_q;
  assign bus.done    = done_q;
  assign bus.nack    = nack_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      b1        <= '0;
      b2        <= '0;
      cur       <= '0;
      bit_idx   <= '0;
      byte_sel  <= '0;
      last_sel  <= '0;
      ack_bit   <= 1'b0;
      sda_low_q <= 1'b0;
      busy_q    <= 1'b0;
      rs_req_q  <= 1'b0;
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
    end else if (bus.abort) begin
      state     <= IDLE;
      sda_low_q <= 1'b0;
      rs_req_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.go) begin
            cur       <= go_b0;
            b1        <= go_b1;
            b2        <= go_b2;
            last_sel  <= mode10_eff ? (bus.rw ? 2'd2 : 2'd1) : 2'd0;
            byte_sel  <= 2'd0;
            bit_idx   <= 3'd7;
            sda_low_q <= ~go_b0[7];
            busy_q    <= 1'b1;
            nack_q    <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.scl_fall) begin
            if (bit_idx != 3'd0) begin
              bit_idx   <= bit_idx - 3'd1;
              sda_low_q <= ~cur[bit_idx - 3'd1];
            end else begin
              sda_low_q <= 1'b0;
              ack_bit   <= 1'b1;  // a missing scl_rise reads as NACK
              state     <= ACK;
            end
          end
        end
        ACK: begin
          if (bus.scl_fall) begin
            if (ack_bit) begin
              nack_q <= 1'b1;
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= FIN;
            end else if (byte_sel == last_sel) begin
              nack_q <= 1'b0;
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= FIN;
            end else if (byte_sel == 2'd0) begin
              byte_sel  <= 2'd1;
              cur       <= b1;
              bit_idx   <= 3'd7;
              sda_low_q <= ~b1[7];
              state     <= SHIFT;
            end else begin
              byte_sel <= 2'd2;
              rs_req_q <= 1'b1;
              state    <= RS_WAIT;
            end
          end else if (bus.scl_rise) begin
            ack_bit <= bus.sda_in;
          end
        end
        RS_WAIT: begin
          if (bus.rs_done) begin
            rs_req_q  <= 1'b0;
            cur       <= b2;
            bit_idx   <= 3'd7;
            sda_low_q <= ~b2[7];
            state     <= SHIFT;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_addr_tx.sv
// Directed bench for i2c_addr_tx: 7-bit, 10-bit write/read, NACK, abort, go-while-busy, async reset.
module tb_i2c_addr_tx;
  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  i2c_addr_tx_if #(.ADDR_W(10)) bus ();

  i2c_addr_tx #(.ADDR_W(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    assert (!(bus.scl_fall && bus.scl_rise)) else begin
      errors++;
      $error("FAIL scl_overlap: observed=1 expected=0");
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [9:0] a, input logic m10, input logic r);
    bus.addr = a; bus.mode10 = m10; bus.rw = r; bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
  endtask

  // One SCL period starting with SCL low; returns the data bit seen on SDA before the rise.
  task automatic scl_bit(input logic slave_sda, output logic line);
    repeat (3) tick();
    line = ~bus.sda_low;
    bus.sda_in = slave_sda; bus.scl_rise = 1'b1;
    tick();
    bus.scl_rise = 1'b0;
    repeat (3) tick();
    bus.scl_fall = 1'b1;
    tick();
    bus.scl_fall = 1'b0;
    bus.sda_in = 1'b1;
  endtask

  task automatic send_byte(input string tag, input logic [7:0] exp, input logic ack, input int go_at);
    logic [7:0] got;
    logic       b;
    got = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == go_at) start(10'h011, 1'b0, 1'b0);
      scl_bit(1'b1, b);
      got = {got[6:0], b};
    end
    check({tag, "_byte"}, 32'(got), 32'(exp));
    check({tag, "_ack_release"}, 32'(bus.sda_low), 0);
    scl_bit(ack, b);
  endtask

  initial begin
    logic b;
    bus.go = 0; bus.abort = 0; bus.addr = '0; bus.rw = 0; bus.mode10 = 0;
    bus.scl_fall = 0; bus.scl_rise = 0; bus.sda_in = 1; bus.rs_done = 0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    check("rst_outputs", {27'd0, bus.sda_low, bus.busy, bus.rs_req, bus.done, bus.nack}, 0);

    // 7-bit read of 0x50 -> 0xA1
    start(10'h050, 1'b0, 1'b1);
    check("b7_busy", 32'(bus.busy), 1);
    check("b7_first_drive", 32'(bus.sda_low), 0);
    send_byte("b7", 8'hA1, 1'b0, -1);
    check("b7_done", 32'(bus.done), 1);
    check("b7_nack", 32'(bus.nack), 0);
    check("b7_busy_fin", 32'(bus.busy), 0);
    tick();
    check("b7_done_pulse", 32'(bus.done), 0);

    // 10-bit write of 0x2A5
    start(10'h2A5, 1'b1, 1'b0);
    check("w10_first_drive", 32'(bus.sda_low), 0);
    send_byte("w10_b0", 8'hF4, 1'b0, -1);
    check("w10_rsreq", 32'(bus.rs_req), 0);
    check("w10_b1_msb", 32'(bus.sda_low), 0);
    send_byte("w10_b1", 8'hA5, 1'b0, -1);
    check("w10_done", 32'(bus.done), 1);
    check("w10_nack", 32'(bus.nack), 0);
    check("w10_rsreq_end", 32'(bus.rs_req), 0);
    tick();

    // 10-bit read of 0x2A5 with repeated START
    start(10'h2A5, 1'b1, 1'b1);
    send_byte("r10_b0", 8'hF4, 1'b0, -1);
    send_byte("r10_b1", 8'hA5, 1'b0, -1);
    check("r10_rsreq", 32'(bus.rs_req), 1);
    check("r10_rs_release", 32'(bus.sda_low), 0);
    scl_bit(1'b1, b);
    repeat (50) tick();
    check("r10_rsreq_held", 32'(bus.rs_req), 1);
    check("r10_rs_busy", 32'(bus.busy), 1);
    bus.rs_done = 1'b1;
    tick();
    bus.rs_done = 1'b0;
    check("r10_rsreq_clr", 32'(bus.rs_req), 0);
    check("r10_b2_msb", 32'(bus.sda_low), 0);
    send_byte("r10_b2", 8'hF5, 1'b0, -1);
    check("r10_done", 32'(bus.done), 1);
    check("r10_nack", 32'(bus.nack), 0);
    tick();

    // NACK on first 10-bit byte
    start(10'h2A5, 1'b1, 1'b0);
    send_byte("nk_b0", 8'hF4, 1'b1, -1);
    check("nk_done", 32'(bus.done), 1);
    check("nk_nack", 32'(bus.nack), 1);
    for (int i = 0; i < 8; i++) begin
      scl_bit(1'b1, b);
      check("nk_no_b1", 32'(bus.sda_low), 0);
    end
    check("nk_nack_held", 32'(bus.nack), 1);
    check("nk_idle", 32'(bus.busy), 0);

    // abort on the scl_fall ending bit 3 of 0xA1
    start(10'h050, 1'b0, 1'b1);
    check("ab_nack_clr", 32'(bus.nack), 0);
    for (int i = 0; i < 4; i++) scl_bit(1'b1, b);
    repeat (3) tick();
    bus.scl_rise = 1'b1;
    tick();
    bus.scl_rise = 1'b0;
    repeat (3) tick();
    check("ab_bit3_drive", 32'(bus.sda_low), 1);
    bus.scl_fall = 1'b1; bus.abort = 1'b1;
    tick();
    bus.scl_fall = 1'b0; bus.abort = 1'b0;
    check("ab_sda", 32'(bus.sda_low), 0);
    check("ab_busy", 32'(bus.busy), 0);
    check("ab_done", 32'(bus.done), 0);
    tick();
    check("ab_no_done", 32'(bus.done), 0);
    start(10'h050, 1'b0, 1'b1);
    send_byte("ab_retry", 8'hA1, 1'b0, -1);
    check("ab_retry_done", 32'(bus.done), 1);
    tick();

    // abort beats go; rs_done in IDLE ignored
    bus.abort = 1'b1;
    start(10'h050, 1'b0, 1'b1);
    bus.abort = 1'b0;
    check("abgo_busy", 32'(bus.busy), 0);
    bus.rs_done = 1'b1;
    tick();
    bus.rs_done = 1'b0;
    check("rsd_idle", {30'd0, bus.busy, bus.rs_req}, 0);

    // go while busy is ignored
    start(10'h050, 1'b0, 1'b1);
    send_byte("gb", 8'hA1, 1'b0, 2);
    check("gb_done", 32'(bus.done), 1);
    check("gb_nack", 32'(bus.nack), 0);
    tick();

    // async reset mid-byte
    start(10'h050, 1'b0, 1'b1);
    scl_bit(1'b1, b);
    check("ar_pre", {30'd0, bus.sda_low, bus.busy}, 3);
    #2 reset_n = 1'b0;
    #1;
    check("ar_outputs", {27'd0, bus.sda_low, bus.busy, bus.rs_req, bus.done, bus.nack}, 0);
    #2 reset_n = 1'b1;
    tick();
    check("ar_idle", {27'd0, bus.sda_low, bus.busy, bus.rs_req, bus.done, bus.nack}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
